// File: rtl/key_press_decoder_pkg.sv
// Shared definitions for the Divergence Meter key path: FSM encoding and
// default key polarity / timing values.
package key_press_decoder_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_REPEAT = 2'd3
  } state_t;

  localparam logic PRESS_LVL_DEF   = 1'b0;
  localparam int   CNT_W_DEF       = 20;
  localparam int   LONG_TIME_DEF   = 50;
  localparam int   REPEAT_TIME_DEF = 20;

endpackage

// File: rtl/key_press_decoder_key_sync.sv
// Two-flop synchroniser for asynchronous pin inputs; the reset value is
// chosen per pin so a freshly reset pin reads as inactive.
module key_sync #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      dout <= RST_VAL;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/key_press_decoder.sv
// Classifies debounced key presses into short / long presses and emits
// auto-repeat pulses while the key stays held. All pulse outputs are registered.
module key_press_decoder
  import key_press_decoder_pkg::*;
#(
  parameter int   CNT_W       = CNT_W_DEF,
  parameter int   LONG_TIME   = LONG_TIME_DEF,
  parameter int   REPEAT_TIME = REPEAT_TIME_DEF,
  parameter logic PRESS_LVL   = PRESS_LVL_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_flag,
  input  logic       key,
  output logic       short_press,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       busy,
  output logic [1:0] dbg_state
);

  if (LONG_TIME < 2 || REPEAT_TIME < 2) begin : g_bad_time
    $error("key_press_decoder: LONG_TIME and REPEAT_TIME must both be >= 2");
  end
  if ($clog2(LONG_TIME) > CNT_W || $clog2(REPEAT_TIME) > CNT_W) begin : g_bad_width
    $error("key_press_decoder: CNT_W too narrow for LONG_TIME/REPEAT_TIME");
  end

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);

  logic [0:0] key_s;
  logic       pressed;
  logic       flag_d;
  logic       rise;
  logic       fall;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             short_nxt, long_nxt, repeat_nxt;

  key_sync #(
    .W       (1),
    .RST_VAL (~PRESS_LVL)
  ) u_key_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (key),
    .dout  (key_s)
  );

  assign pressed = (key_s[0] == PRESS_LVL);

  // key_flag comes from the synchronous debounce stage, so one register is enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_d <= 1'b0;
    end else begin
      flag_d <= key_flag;
    end
  end

  assign rise = key_flag & ~flag_d;
  assign fall = ~key_flag & flag_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Release is tested before the terminal count so it always wins a tie.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        if (fall) begin
          cnt_nxt = '0;
          if (pressed) begin
            state_nxt = S_HOLD;
          end else begin
            short_nxt = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (!pressed) begin
          short_nxt = 1'b1;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = S_REPEAT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = (cnt < LONG_LAST) ? cnt + 1'b1 : LONG_LAST;
        end
      end
      S_REPEAT: begin
        if (!pressed) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == REPEAT_LAST) begin
          repeat_nxt = 1'b1;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = (cnt < REPEAT_LAST) ? cnt + 1'b1 : REPEAT_LAST;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      repeat_pulse <= repeat_nxt;
    end
  end

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule
